// File: rtl/instr_fetch.sv
// Instruction-fetch stage: PC, single-outstanding fetch FSM, fetch queue and the IF/ID register.
// Build option INSTR_FETCH_QUEUE_EN selects a QDEPTH-entry circular queue; otherwise one holding register.
module instr_fetch #(
  parameter logic [63:0] RESET_PC = 64'h0,
  parameter int unsigned QDEPTH   = 2
) (
  input  logic        clk,
  input  logic        reset,
  output logic        imem_req,
  output logic [63:0] imem_addr,
  input  logic        imem_ready,
  input  logic        imem_rvalid,
  input  logic [31:0] imem_rdata,
  input  logic        br_taken,
  input  logic [63:0] br_target,
  input  logic        stall,
  output logic        out_valid,
  output logic [31:0] out_instr,
  output logic [63:0] out_pc
);

`ifdef INSTR_FETCH_QUEUE_EN
  localparam int unsigned D = QDEPTH;
`else
  // QDEPTH has no effect here; it stays referenced so both builds share one parameter list.
  localparam int unsigned D = (QDEPTH > 0) ? 1 : 1;
`endif
  localparam int unsigned CW = $clog2(D + 1);

  typedef enum logic [1:0] {IDLE, WAIT, DROP} fetchState_t;

  fetchState_t   state;
  logic [63:0]   pc;
  logic [63:0]   reqPc;
  logic [CW-1:0] count;
  logic [63:0]   headPc;
  logic [31:0]   headInstr;
  logic          accept;
  logic          push;
  logic          pop;
  logic          qNotEmpty;

  assign qNotEmpty = (count != '0);
  assign imem_req  = (state == IDLE) && !br_taken && (count < CW'(D));
  assign imem_addr = pc;
  assign accept    = imem_req && imem_ready;
  assign push      = (state == WAIT) && imem_rvalid && !br_taken;
  assign pop       = !br_taken && !(stall && out_valid) && qNotEmpty;

`ifdef INSTR_FETCH_QUEUE_EN
  localparam int unsigned PW = (D > 1) ? $clog2(D) : 1;

  logic [63:0]   qPc    [D];
  logic [31:0]   qInstr [D];
  logic [PW-1:0] head;
  logic [PW-1:0] tail;

  function automatic logic [PW-1:0] nextPtr(input logic [PW-1:0] p);
    return (p == PW'(D - 1)) ? '0 : p + PW'(1);
  endfunction

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      head <= '0;
      tail <= '0;
      for (int unsigned i = 0; i < D; i++) begin
        qPc[i]    <= '0;
        qInstr[i] <= '0;
      end
    end else if (br_taken) begin
      head <= '0;
      tail <= '0;
    end else begin
      if (push) begin
        qPc[tail]    <= reqPc;
        qInstr[tail] <= imem_rdata;
        tail         <= nextPtr(tail);
      end
      if (pop) head <= nextPtr(head);
    end
  end

  assign headPc    = qPc[head];
  assign headInstr = qInstr[head];
`else
  logic [63:0] holdPc;
  logic [31:0] holdInstr;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      holdPc    <= '0;
      holdInstr <= '0;
    end else if (push) begin
      holdPc    <= reqPc;
      holdInstr <= imem_rdata;
    end
  end

  assign headPc    = holdPc;
  assign headInstr = holdInstr;
`endif

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state     <= IDLE;
      pc        <= RESET_PC;
      reqPc     <= '0;
      count     <= '0;
      out_valid <= 1'b0;
      out_instr <= '0;
      out_pc    <= '0;
    end else begin
      // A redirect while WAIT leaves the response pending, so DROP swallows it later.
      case (state)
        IDLE: if (accept) begin
          state <= WAIT;
          reqPc <= pc;
        end
        WAIT: begin
          if (imem_rvalid)   state <= IDLE;
          else if (br_taken) state <= DROP;
        end
        DROP: if (imem_rvalid) state <= IDLE;
        default: state <= IDLE;
      endcase

      if (br_taken)    pc <= br_target & ~64'h3;
      else if (accept) pc <= pc + 64'd4;

      if (br_taken)           count <= '0;
      else if (push && !pop)  count <= count + CW'(1);
      else if (pop && !push)  count <= count - CW'(1);

      if (br_taken) begin
        out_valid <= 1'b0;
      end else if (!(stall && out_valid)) begin
        if (qNotEmpty) begin
          out_valid <= 1'b1;
          out_instr <= headInstr;
          out_pc    <= headPc;
        end else begin
          out_valid <= 1'b0;
        end
      end
    end
  end

endmodule

// File: tb/tb_instr_fetch.sv
// Self-checking bench for instr_fetch: reset/throughput vector table, directed corner sequences,
// then randomized traffic compared against a queue-based reference model.
module tb_instr_fetch;
  localparam logic [63:0] RPC = 64'h100;
`ifdef INSTR_FETCH_QUEUE_EN
  localparam int D = 4;
`else
  localparam int D = 1;
`endif

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        imem_req;
  logic [63:0] imem_addr;
  logic        imem_ready = 1'b1;
  logic        imem_rvalid = 1'b0;
  logic [31:0] imem_rdata = '0;
  logic        br_taken = 1'b0;
  logic [63:0] br_target = '0;
  logic        stall = 1'b0;
  logic        out_valid;
  logic [31:0] out_instr;
  logic [63:0] out_pc;

  int checks = 0;
  int errors = 0;

  instr_fetch #(.RESET_PC(RPC), .QDEPTH(4)) dut (
    .clk(clk), .reset(reset),
    .imem_req(imem_req), .imem_addr(imem_addr), .imem_ready(imem_ready),
    .imem_rvalid(imem_rvalid), .imem_rdata(imem_rdata),
    .br_taken(br_taken), .br_target(br_target), .stall(stall),
    .out_valid(out_valid), .out_instr(out_instr), .out_pc(out_pc)
  );

  always #5 clk = ~clk;

  // Reference model: instruction queue plus "request outstanding / still wanted" flags.
  typedef struct { logic [63:0] pc; logic [31:0] instr; } ent_t;
  ent_t        mQ[$];
  logic [63:0] mPc, mReqPc, mOutPc;
  logic [31:0] mOutInstr;
  bit          mBusy, mKeep, mOutValid;

  // Memory responder state.
  bit          memPending, lastAcc;
  int          memDue, memLat, cyc;
  logic [63:0] memAddr;

  function automatic logic mReq();
    return !mBusy && !br_taken && (mQ.size() < D);
  endfunction

  function automatic void modelReset();
    mPc = RPC; mReqPc = '0; mBusy = 0; mKeep = 0; mQ.delete();
    mOutValid = 0; mOutInstr = '0; mOutPc = '0;
  endfunction

  function automatic void modelStep(output bit acc);
    ent_t h, e;
    acc = mReq() && imem_ready;
    if (br_taken) mOutValid = 0;
    else if (!(stall && mOutValid)) begin
      if (mQ.size() > 0) begin
        h = mQ.pop_front();
        mOutValid = 1; mOutPc = h.pc; mOutInstr = h.instr;
      end else mOutValid = 0;
    end
    if (br_taken) mQ.delete();
    if (mBusy && imem_rvalid) begin
      if (mKeep && !br_taken) begin
        e.pc = mReqPc; e.instr = imem_rdata; mQ.push_back(e);
      end
      mBusy = 0;
    end else if (mBusy && br_taken) mKeep = 0;
    if (acc) begin mBusy = 1; mKeep = 1; mReqPc = mPc; end
    if (br_taken) mPc = {br_target[63:2], 2'b00};
    else if (acc) mPc = mPc + 64'd4;
  endfunction

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic timeoutFail(input string name);
    checks++; errors++;
    $display("FAIL %s: wait bound expired without the required event (t=%0t)", name, $time);
  endtask

  task automatic sample();
    @(negedge clk);
    chk("imem_req", imem_req, mReq());
    chk("imem_addr", imem_addr, mPc);
    chk("out_valid", out_valid, mOutValid);
    chk("out_instr", out_instr, mOutInstr);
    chk("out_pc", out_pc, mOutPc);
  endtask

  task automatic advance();
    bit acc;
    @(posedge clk);
    acc = 0;
    if (!reset) modelReset();
    else modelStep(acc);
    if (imem_rvalid && memPending && cyc == memDue) memPending = 0;
    if (acc) begin memPending = 1; memDue = cyc + memLat; memAddr = mReqPc; end
    lastAcc = acc;
    cyc++;
    #1;
    imem_rvalid = memPending && (cyc == memDue);
    imem_rdata  = 32'h8B00_0000 + memAddr[31:0];
  endtask

  task automatic step();
    sample();
    advance();
  endtask

  task automatic doReset();
    reset = 0; modelReset(); memPending = 0; imem_rvalid = 0;
    stall = 0; br_taken = 0; imem_ready = 1;
    step();
    reset = 1;
  endtask

  task automatic waitAcc(input string name);
    int n;
    n = 0;
    do begin step(); n++; end while (!lastAcc && n < 30);
    if (!lastAcc) timeoutFail(name);
  endtask

  task automatic waitValid(input string name, input logic [63:0] expPc);
    for (int k = 0; k < 40; k++) begin
      sample();
      if (out_valid) begin
        chk(name, out_pc, expPc);
        advance();
        return;
      end
      advance();
    end
    timeoutFail(name);
  endtask

  typedef struct { logic req; logic [63:0] addr; logic valid; logic [63:0] pc; } vec_t;
  vec_t tbl[$];

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    logic [31:0] expI;
    modelReset(); memPending = 0; cyc = 0; memLat = 1; lastAcc = 0;

    // Expected cycles from reset release with an always-ready, 1-cycle memory.
`ifdef INSTR_FETCH_QUEUE_EN
    tbl.push_back('{1'b1, 64'h100, 1'b0, 64'h0});
    tbl.push_back('{1'b0, 64'h104, 1'b0, 64'h0});
    tbl.push_back('{1'b1, 64'h104, 1'b0, 64'h0});
    tbl.push_back('{1'b0, 64'h108, 1'b1, 64'h100});
    tbl.push_back('{1'b1, 64'h108, 1'b0, 64'h100});
    tbl.push_back('{1'b0, 64'h10C, 1'b1, 64'h104});
    tbl.push_back('{1'b1, 64'h10C, 1'b0, 64'h104});
    tbl.push_back('{1'b0, 64'h110, 1'b1, 64'h108});
`else
    tbl.push_back('{1'b1, 64'h100, 1'b0, 64'h0});
    tbl.push_back('{1'b0, 64'h104, 1'b0, 64'h0});
    tbl.push_back('{1'b0, 64'h104, 1'b0, 64'h0});
    tbl.push_back('{1'b1, 64'h104, 1'b1, 64'h100});
    tbl.push_back('{1'b0, 64'h108, 1'b0, 64'h100});
    tbl.push_back('{1'b0, 64'h108, 1'b0, 64'h100});
    tbl.push_back('{1'b1, 64'h108, 1'b1, 64'h104});
    tbl.push_back('{1'b0, 64'h10C, 1'b0, 64'h104});
    tbl.push_back('{1'b0, 64'h10C, 1'b0, 64'h104});
    tbl.push_back('{1'b1, 64'h10C, 1'b1, 64'h108});
`endif

    reset = 0;
    repeat (2) step();
    @(negedge clk);
    chk("rst_out_valid", out_valid, 0);
    chk("rst_out_instr", out_instr, 0);
    chk("rst_out_pc", out_pc, 0);
    chk("rst_imem_addr", imem_addr, RPC);
    advance();
    reset = 1;

    foreach (tbl[i]) begin
      sample();
      expI = (tbl[i].pc == 64'h0) ? 32'h0 : 32'h8B00_0000 + tbl[i].pc[31:0];
      chk("tbl_req", imem_req, tbl[i].req);
      chk("tbl_addr", imem_addr, tbl[i].addr);
      chk("tbl_valid", out_valid, tbl[i].valid);
      chk("tbl_pc", out_pc, tbl[i].pc);
      chk("tbl_instr", out_instr, expI);
      advance();
    end

    // Stall while 0x104 is in IF/ID: frozen outputs, queue fills, then 0x108 next.
    doReset();
    n = 0;
    while (!(mOutValid && mOutPc == 64'h104) && n < 30) begin step(); n++; end
    if (n == 30) timeoutFail("stall_setup");
    stall = 1;
    for (int k = 0; k < 5; k++) begin
      sample();
      chk("stall_hold_valid", out_valid, 1);
      chk("stall_hold_pc", out_pc, 64'h104);
      advance();
    end
    n = 0;
    while (mQ.size() < D && n < 30) begin step(); n++; end
    if (n == 30) timeoutFail("stall_fill");
    sample();
    chk("stall_full_req", imem_req, 0);
    chk("stall_full_pc", out_pc, 64'h104);
    advance();
    stall = 0;
    step();
    sample();
    chk("stall_next_valid", out_valid, 1);
    chk("stall_next_pc", out_pc, 64'h108);
    advance();

    // Redirect while WAIT with a slow memory: stale response dropped.
    memLat = 3;
    waitAcc("redir_setup");
    br_taken = 1; br_target = 64'h203;
    step();
    br_taken = 0; memLat = 1;
    sample();
    chk("redir_addr", imem_addr, 64'h200);
    chk("redir_bubble", out_valid, 0);
    advance();
    waitValid("redir_first_pc", 64'h200);

    // Redirect coinciding with a response while stall holds a valid IF/ID.
    n = 0;
    while (!mOutValid && n < 30) begin step(); n++; end
    if (n == 30) timeoutFail("flush_setup_valid");
    stall = 1;
    n = 0;
    while (!imem_rvalid && n < 30) begin step(); n++; end
    if (n == 30) timeoutFail("flush_setup_rvalid");
    br_taken = 1; br_target = 64'h300;
    step();
    br_taken = 0;
    sample();
    chk("flush_beats_stall", out_valid, 0);
    advance();
    stall = 0;
    waitValid("flush_first_pc", 64'h300);

    // Reset pulse while WAIT; the late response lands while IDLE.
    memLat = 3;
    waitAcc("rstpulse_setup");
    reset = 0; imem_ready = 0; modelReset();
    sample();
    chk("rstpulse_valid", out_valid, 0);
    chk("rstpulse_addr", imem_addr, RPC);
    advance();
    reset = 1;
    step();
    step();
    imem_ready = 1; memLat = 1;
    sample();
    chk("rstpulse_req", imem_req, 1);
    chk("rstpulse_restart", imem_addr, RPC);
    advance();
    waitValid("rstpulse_first_pc", RPC);

    // PC wrap at the top of the address space.
    br_taken = 1; br_target = 64'hFFFF_FFFF_FFFF_FFFC;
    step();
    br_taken = 0;
    waitAcc("wrap_setup");
    sample();
    chk("wrap_addr", imem_addr, 64'h0);
    advance();
    waitValid("wrap_first_pc", 64'hFFFF_FFFF_FFFF_FFFC);

    // Randomized traffic against the model.
    for (int k = 0; k < 3000; k++) begin
      imem_ready = ($urandom_range(0, 3) != 0);
      stall      = ($urandom_range(0, 3) == 0);
      br_taken   = ($urandom_range(0, 11) == 0);
      br_target  = {$urandom, $urandom};
      memLat     = $urandom_range(1, 3);
      if (!memPending && $urandom_range(0, 15) == 0) begin
        imem_rvalid = 1; imem_rdata = $urandom;
      end
      step();
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
